toysram_16x12_ctl: RTL and testbench
====================================

Name: toysram_16x12_ctl

Overview:
- Synchronous port controller that drives one 16x12 toysram subarray.
- Turns clocked read/write requests into one-hot read word lines (RWL0/RWL1), timed write pulses (WWL) and differential write bit lines (WBL/WBLb).
- Captures the read bit lines (RBL0/RBL1) into registered read data.
- Sits between the array-shard request logic and the subarray; one write port, two independent read ports.

Parameters:
- WR_SETUP, 1, cycles bit lines are driven before WWL rises (1..7)
- WR_PULSE, 1, cycles WWL is held high (1..7)
- WR_HOLD, 1, cycles bit lines are held after WWL falls (1..7)

Ports:
- clk  in  1  single clock; all logic on rising edge
- reset  in  1  asynchronous, active-high reset
- wr_val  in  1  write request valid
- wr_rdy  out  1  controller can accept a write
- wr_adr  in  [0:3]  write row
- wr_dat  in  [0:11]  write data
- wr_done  out  1  one-cycle pulse in the last HOLD cycle
- rd0_val  in  1  read port 0 request
- rd0_adr  in  [0:3]  read port 0 row
- rd0_dat  out  [0:11]  read port 0 data
- rd0_dat_val  out  1  rd0_dat valid
- rd0_coll  out  1  read 0 overlapped a write pulse to the same row
- rd1_val, rd1_adr, rd1_dat, rd1_dat_val, rd1_coll  same as port 0, for port 1
- RWL0  out  [0:15]  subarray read word lines, port 0
- RWL1  out  [0:15]  subarray read word lines, port 1
- WWL  out  [0:15]  subarray write word lines
- WBL  out  [0:11]  write bit lines, true
- WBLb  out  [0:11]  write bit lines, complement
- RBL0  in  [0:11]  subarray read bit lines, port 0
- RBL1  in  [0:11]  subarray read bit lines, port 1

Behaviour:
- Reset values (asynchronous):
  - RWL0, RWL1, WWL, WBL, WBLb = 0
  - wr_rdy = 0 while reset is asserted; 1 in the first cycle after release
  - wr_done, rd*_dat_val, rd*_coll = 0; rd*_dat = 0
  - Write FSM = IDLE
- Write FSM states: IDLE, SETUP, PULSE, HOLD.
  - Each state has a 3-bit down-counter loaded from its parameter.
  - IDLE: wr_rdy=1. If wr_val, register wr_adr/wr_dat and go to SETUP.
  - SETUP: WBL=dat, WBLb=~dat, WWL=0. Stay WR_SETUP cycles, then go to PULSE.
  - PULSE: WWL[adr]=1 (exactly one bit), bit lines held. Stay WR_PULSE cycles, then go to HOLD.
  - HOLD: WWL=0, bit lines held. Stay WR_HOLD cycles; wr_done=1 in the last one; then go to IDLE.
  - On IDLE entry: WBL and WBLb return to 0 (no drive).
  - wr_rdy=0 in every non-IDLE state. wr_val while not ready is ignored; the requester must hold it.
  - All word-line and bit-line outputs are driven from flops, so they are glitch-free per cycle.
- Write timing with defaults:
  - Accept in cycle T; SETUP in T+1; WWL high in T+2; HOLD in T+3 with wr_done; IDLE in T+4.
  - Next accept is possible in T+4 at the earliest (back-to-back writes every 4 cycles).
- Read port N (N=0,1), fully pipelined, one read per cycle per port, ports independent:
  - Request in cycle T.
  - RWLN one-hot at rdN_adr, high only during T+1 (registered decode; all zero otherwise).
  - RBLN captured at the rising edge ending T+1.
  - rdN_dat and rdN_dat_val=1 during T+2; rdN_dat holds its value when rdN_dat_val=0.
  - Back-to-back reads move RWLN between rows on consecutive cycles with no idle cycle.
- Collision handling:
  - If, in the RWLN-active cycle, WWL is high on the same row, rdN_coll=1 alongside rdN_dat_val.
  - Data is still captured but is architecturally unreliable.
  - Both ports reading the same row in the same cycle is legal and raises no flag.
- Reset mid-write: WWL and the bit lines drop asynchronously, no wr_done is produced, and the target row contents are undefined.
- Reset mid-read: the pending rd*_dat_val is discarded.

Test Plan:
- Reset release, write adr=5 dat=0xA5C, default params -> WWL=0x0400 (bit 5) high exactly 1 cycle, 2 cycles after accept; WBL=0xA5C and WBLb=0x5A3 from SETUP through HOLD; wr_done in T+3; wr_rdy back to 1 in T+4.
- Write rows 0..15 with data 0x100+row, then read port 0 row 3 and port 1 row 12 in the same cycle -> both rd*_dat_val 2 cycles later, rd0_dat=0x103, rd1_dat=0x10C, no coll.
- Streaming reads: port 0 reads rows 0,1,2,3 on consecutive cycles -> RWL0 walks 0x8000, 0x4000, 0x2000, 0x1000 one cycle each; data valid on 4 consecutive cycles in order.
- Parameters WR_SETUP=2, WR_PULSE=3, WR_HOLD=2 -> WWL high 3 cycles starting T+3; wr_done at T+7; wr_rdy=0 for T+1..T+7; a wr_val held during busy is accepted only at T+8.
- Collision: write row 7; port 1 reads row 7 timed so RWL1 is active during PULSE -> rd1_coll=1 with rd1_dat_val. A read of row 8 in the same cycle -> coll=0.
- Assert reset during PULSE -> WWL=0 and WBL/WBLb=0 immediately; no wr_done; wr_rdy=1 in the first cycle after release.

Source files
------------

// File: rtl/toysram_16x12_ctl.sv
// Port controller for one 16x12 toysram subarray: a timed write sequencer
// (setup / pulse / hold) and two independent, fully pipelined read ports.
module toysram_16x12_ctl #(
    parameter int unsigned WR_SETUP = 1,
    parameter int unsigned WR_PULSE = 1,
    parameter int unsigned WR_HOLD  = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_val,
    output logic        wr_rdy,
    input  logic [0:3]  wr_adr,
    input  logic [0:11] wr_dat,
    output logic        wr_done,
    input  logic        rd0_val,
    input  logic [0:3]  rd0_adr,
    output logic [0:11] rd0_dat,
    output logic        rd0_dat_val,
    output logic        rd0_coll,
    input  logic        rd1_val,
    input  logic [0:3]  rd1_adr,
    output logic [0:11] rd1_dat,
    output logic        rd1_dat_val,
    output logic        rd1_coll,
    output logic [0:15] RWL0,
    output logic [0:15] RWL1,
    output logic [0:15] WWL,
    output logic [0:11] WBL,
    output logic [0:11] WBLb,
    input  logic [0:11] RBL0,
    input  logic [0:11] RBL1
);

    typedef enum logic [1:0] {StIdle, StSetup, StPulse, StHold} wr_state_e;

    wr_state_e   state_q;
    logic [2:0]  cnt_q;
    logic [0:3]  adr_q;
    logic [0:15] wwl_q;
    logic [0:11] wbl_q;
    logic [0:11] wblb_q;
    logic        done_q;

    logic [0:15] rwl0_q, rwl1_q;
    logic [0:11] rd0_dat_q, rd1_dat_q;
    logic        rd0_val_q, rd1_val_q;
    logic        rd0_coll_q, rd1_coll_q;

    function automatic logic [0:15] row_dec(input logic [0:3] a);
        logic [0:15] r;
        r    = '0;
        r[a] = 1'b1;
        return r;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            adr_q   <= '0;
            wwl_q   <= '0;
            wbl_q   <= '0;
            wblb_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    done_q <= 1'b0;
                    if (wr_val) begin
                        state_q <= StSetup;
                        cnt_q   <= 3'(WR_SETUP - 1);
                        adr_q   <= wr_adr;
                        wbl_q   <= wr_dat;
                        wblb_q  <= ~wr_dat;
                    end
                end
                StSetup: begin
                    if (cnt_q == 3'd0) begin
                        state_q <= StPulse;
                        cnt_q   <= 3'(WR_PULSE - 1);
                        wwl_q   <= row_dec(adr_q);
                    end else begin
                        cnt_q <= cnt_q - 3'd1;
                    end
                end
                StPulse: begin
                    if (cnt_q == 3'd0) begin
                        state_q <= StHold;
                        cnt_q   <= 3'(WR_HOLD - 1);
                        wwl_q   <= '0;
                        done_q  <= (WR_HOLD == 1);
                    end else begin
                        cnt_q <= cnt_q - 3'd1;
                    end
                end
                StHold: begin
                    if (cnt_q == 3'd0) begin
                        // Release the bit lines as the array returns to idle.
                        state_q <= StIdle;
                        wbl_q   <= '0;
                        wblb_q  <= '0;
                        done_q  <= 1'b0;
                    end else begin
                        cnt_q  <= cnt_q - 3'd1;
                        done_q <= (cnt_q == 3'd1);
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Read pipeline: decode word line in T+1, capture bit lines at its end.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rwl0_q     <= '0;
            rwl1_q     <= '0;
            rd0_dat_q  <= '0;
            rd1_dat_q  <= '0;
            rd0_val_q  <= 1'b0;
            rd1_val_q  <= 1'b0;
            rd0_coll_q <= 1'b0;
            rd1_coll_q <= 1'b0;
        end else begin
            rwl0_q     <= rd0_val ? row_dec(rd0_adr) : '0;
            rwl1_q     <= rd1_val ? row_dec(rd1_adr) : '0;
            rd0_val_q  <= |rwl0_q;
            rd1_val_q  <= |rwl1_q;
            rd0_coll_q <= |(rwl0_q & wwl_q);
            rd1_coll_q <= |(rwl1_q & wwl_q);
            if (|rwl0_q) rd0_dat_q <= RBL0;
            if (|rwl1_q) rd1_dat_q <= RBL1;
        end
    end

    assign wr_rdy      = (state_q == StIdle) && !reset;
    assign wr_done     = done_q;
    assign WWL         = wwl_q;
    assign WBL         = wbl_q;
    assign WBLb        = wblb_q;
    assign RWL0        = rwl0_q;
    assign RWL1        = rwl1_q;
    assign rd0_dat     = rd0_dat_q;
    assign rd1_dat     = rd1_dat_q;
    assign rd0_dat_val = rd0_val_q;
    assign rd1_dat_val = rd1_val_q;
    assign rd0_coll    = rd0_coll_q;
    assign rd1_coll    = rd1_coll_q;

endmodule

// File: tb/tb_toysram_16x12_ctl.sv
// Directed bench for toysram_16x12_ctl with a behavioural 16x12 subarray model.
module tb_toysram_16x12_ctl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        wr_val = 1'b0;
    logic [0:3]  wr_adr = '0;
    logic [0:11] wr_dat = '0;
    logic        rd0_val = 1'b0, rd1_val = 1'b0;
    logic [0:3]  rd0_adr = '0, rd1_adr = '0;
    logic        wr_rdy, wr_done;
    logic [0:11] rd0_dat, rd1_dat;
    logic        rd0_dat_val, rd1_dat_val, rd0_coll, rd1_coll;
    logic [0:15] RWL0, RWL1, WWL;
    logic [0:11] WBL, WBLb, RBL0, RBL1;

    logic        w2_val = 1'b0;
    logic [0:3]  w2_adr = '0;
    logic [0:11] w2_dat = '0;
    logic        w2_rdy, w2_done;
    logic [0:11] x2_rd0_dat, x2_rd1_dat;
    logic        x2_rd0_v, x2_rd1_v, x2_rd0_c, x2_rd1_c;
    logic [0:15] x2_rwl0, x2_rwl1, w2_wwl;
    logic [0:11] w2_wbl, w2_wblb;

    int vectors = 0;
    int miscompares = 0;

    logic [0:11] mem [16];

    always #5 clk = ~clk;

    toysram_16x12_ctl dut (
        .clk(clk), .reset(reset),
        .wr_val(wr_val), .wr_rdy(wr_rdy), .wr_adr(wr_adr), .wr_dat(wr_dat), .wr_done(wr_done),
        .rd0_val(rd0_val), .rd0_adr(rd0_adr), .rd0_dat(rd0_dat), .rd0_dat_val(rd0_dat_val),
        .rd0_coll(rd0_coll),
        .rd1_val(rd1_val), .rd1_adr(rd1_adr), .rd1_dat(rd1_dat), .rd1_dat_val(rd1_dat_val),
        .rd1_coll(rd1_coll),
        .RWL0(RWL0), .RWL1(RWL1), .WWL(WWL), .WBL(WBL), .WBLb(WBLb), .RBL0(RBL0), .RBL1(RBL1)
    );

    toysram_16x12_ctl #(.WR_SETUP(2), .WR_PULSE(3), .WR_HOLD(2)) dut2 (
        .clk(clk), .reset(reset),
        .wr_val(w2_val), .wr_rdy(w2_rdy), .wr_adr(w2_adr), .wr_dat(w2_dat), .wr_done(w2_done),
        .rd0_val(1'b0), .rd0_adr(4'd0), .rd0_dat(x2_rd0_dat), .rd0_dat_val(x2_rd0_v),
        .rd0_coll(x2_rd0_c),
        .rd1_val(1'b0), .rd1_adr(4'd0), .rd1_dat(x2_rd1_dat), .rd1_dat_val(x2_rd1_v),
        .rd1_coll(x2_rd1_c),
        .RWL0(x2_rwl0), .RWL1(x2_rwl1), .WWL(w2_wwl), .WBL(w2_wbl), .WBLb(w2_wblb),
        .RBL0(12'd0), .RBL1(12'd0)
    );

    // Subarray model: write on rising edge under WWL, read combinationally via RWL.
    always @(posedge clk) begin
        for (int r = 0; r < 16; r++) begin
            if (WWL[r]) mem[r] <= WBL;
        end
    end

    always_comb begin
        RBL0 = '0;
        RBL1 = '0;
        for (int r = 0; r < 16; r++) begin
            if (RWL0[r]) RBL0 = RBL0 | mem[r];
            if (RWL1[r]) RBL1 = RBL1 | mem[r];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset
        #1 reset = 1'b1;
        tick();
        check("rst_rdy", 32'(wr_rdy), 0);
        check("rst_wwl", 32'(WWL), 0);
        check("rst_wbl", 32'(WBL), 0);
        check("rst_wblb", 32'(WBLb), 0);
        check("rst_rwl0", 32'(RWL0), 0);
        check("rst_rd0v", 32'(rd0_dat_val), 0);
        check("rst_done", 32'(wr_done), 0);
        tick();
        reset = 1'b0;
        #1;
        check("rel_rdy", 32'(wr_rdy), 1);

        // Single write, default timing
        wr_val = 1'b1; wr_adr = 4'd5; wr_dat = 12'hA5C;
        tick();
        wr_val = 1'b0;
        check("w1_setup_wbl", 32'(WBL), 32'hA5C);
        check("w1_setup_wblb", 32'(WBLb), 32'h5A3);
        check("w1_setup_wwl", 32'(WWL), 0);
        check("w1_setup_rdy", 32'(wr_rdy), 0);
        check("w1_setup_done", 32'(wr_done), 0);
        tick();
        check("w1_pulse_wwl", 32'(WWL), 32'h0400);
        check("w1_pulse_wbl", 32'(WBL), 32'hA5C);
        check("w1_pulse_done", 32'(wr_done), 0);
        tick();
        check("w1_hold_wwl", 32'(WWL), 0);
        check("w1_hold_done", 32'(wr_done), 1);
        check("w1_hold_wblb", 32'(WBLb), 32'h5A3);
        check("w1_hold_rdy", 32'(wr_rdy), 0);
        tick();
        check("w1_idle_rdy", 32'(wr_rdy), 1);
        check("w1_idle_wbl", 32'(WBL), 0);
        check("w1_idle_wblb", 32'(WBLb), 0);
        check("w1_idle_done", 32'(wr_done), 0);

        // Fill all rows, back-to-back every 4 cycles
        for (int r = 0; r < 16; r++) begin
            check("fill_rdy", 32'(wr_rdy), 1);
            wr_val = 1'b1; wr_adr = 4'(r); wr_dat = 12'(32'h100 + r);
            tick();
            wr_val = 1'b0;
            tick();
            tick();
            tick();
        end

        // Dual-port read
        rd0_val = 1'b1; rd0_adr = 4'd3; rd1_val = 1'b1; rd1_adr = 4'd12;
        tick();
        rd0_val = 1'b0; rd1_val = 1'b0;
        check("dual_rwl0", 32'(RWL0), 32'h1000);
        check("dual_rwl1", 32'(RWL1), 32'h0008);
        check("dual_v0_early", 32'(rd0_dat_val), 0);
        tick();
        check("dual_v0", 32'(rd0_dat_val), 1);
        check("dual_v1", 32'(rd1_dat_val), 1);
        check("dual_d0", 32'(rd0_dat), 32'h103);
        check("dual_d1", 32'(rd1_dat), 32'h10C);
        check("dual_c0", 32'(rd0_coll), 0);
        check("dual_c1", 32'(rd1_coll), 0);
        check("dual_rwl0_off", 32'(RWL0), 0);
        tick();
        check("dual_v0_drop", 32'(rd0_dat_val), 0);
        check("dual_d0_hold", 32'(rd0_dat), 32'h103);

        // Both ports on the same row
        rd0_val = 1'b1; rd0_adr = 4'd2; rd1_val = 1'b1; rd1_adr = 4'd2;
        tick();
        rd0_val = 1'b0; rd1_val = 1'b0;
        tick();
        check("same_d0", 32'(rd0_dat), 32'h102);
        check("same_d1", 32'(rd1_dat), 32'h102);
        check("same_c0", 32'(rd0_coll), 0);
        check("same_c1", 32'(rd1_coll), 0);
        tick();

        // Streaming reads on port 0
        for (int i = 0; i < 6; i++) begin
            if (i >= 1 && i <= 4) check("strm_rwl0", 32'(RWL0), 32'h8000 >> (i - 1));
            if (i >= 2) begin
                check("strm_v0", 32'(rd0_dat_val), 1);
                check("strm_d0", 32'(rd0_dat), 32'h100 + i - 2);
            end
            if (i < 4) begin
                rd0_val = 1'b1; rd0_adr = 4'(i);
            end else begin
                rd0_val = 1'b0;
            end
            tick();
        end
        check("strm_end_v0", 32'(rd0_dat_val), 0);
        check("strm_end_rwl0", 32'(RWL0), 0);

        // Long timing instance; request held while busy with different data
        w2_val = 1'b1; w2_adr = 4'd9; w2_dat = 12'h3C3;
        for (int k = 0; k < 10; k++) begin
            check("p2_rdy", 32'(w2_rdy), (k == 0 || k == 8) ? 1 : 0);
            check("p2_wwl", 32'(w2_wwl), (k >= 3 && k <= 5) ? 32'h0040 : 0);
            check("p2_done", 32'(w2_done), (k == 7) ? 1 : 0);
            if (k >= 1 && k <= 7) check("p2_wbl", 32'(w2_wbl), 32'h3C3);
            if (k == 9) check("p2_reaccept_wbl", 32'(w2_wbl), 32'h5A5);
            if (k == 1) w2_dat = 12'h5A5;
            if (k == 9) w2_val = 1'b0;
            tick();
        end
        for (int k = 0; k < 8; k++) tick();
        check("p2_back_idle", 32'(w2_rdy), 1);

        // Collision on row 7, clean read of row 8 in the same cycle
        wr_val = 1'b1; wr_adr = 4'd7; wr_dat = 12'hFFF;
        tick();
        wr_val = 1'b0;
        rd1_val = 1'b1; rd1_adr = 4'd7; rd0_val = 1'b1; rd0_adr = 4'd8;
        tick();
        rd0_val = 1'b0; rd1_val = 1'b0;
        check("coll_wwl", 32'(WWL), 32'h0100);
        check("coll_rwl1", 32'(RWL1), 32'h0100);
        tick();
        check("coll_v1", 32'(rd1_dat_val), 1);
        check("coll_c1", 32'(rd1_coll), 1);
        check("coll_v0", 32'(rd0_dat_val), 1);
        check("coll_c0", 32'(rd0_coll), 0);
        check("coll_d0", 32'(rd0_dat), 32'h108);
        tick();
        check("coll_c1_clear", 32'(rd1_coll), 0);

        // Reset during PULSE, with a read in flight
        wr_val = 1'b1; wr_adr = 4'd1; wr_dat = 12'h0F0;
        tick();
        wr_val = 1'b0;
        rd0_val = 1'b1; rd0_adr = 4'd4;
        tick();
        rd0_val = 1'b0;
        check("mid_wwl", 32'(WWL), 32'h4000);
        #2 reset = 1'b1;
        #1;
        check("mid_rst_wwl", 32'(WWL), 0);
        check("mid_rst_wbl", 32'(WBL), 0);
        check("mid_rst_wblb", 32'(WBLb), 0);
        check("mid_rst_rdy", 32'(wr_rdy), 0);
        check("mid_rst_rwl0", 32'(RWL0), 0);
        tick();
        reset = 1'b0;
        #1;
        check("mid_rel_rdy", 32'(wr_rdy), 1);
        check("mid_rel_done", 32'(wr_done), 0);
        check("mid_rel_v0", 32'(rd0_dat_val), 0);
        check("mid_rel_d0", 32'(rd0_dat), 0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("post_done", 32'(wr_done), 0);
            check("post_wwl", 32'(WWL), 0);
            check("post_v0", 32'(rd0_dat_val), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
